muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit with architectural HI/LO registers for the EX stage of the 5-stage pipeline.
//  Executes MULT/MULTU/DIV/DIVU over WIDTH+1 cycles and MTHI/MTLO in one cycle.
//  Serves mfhi/mflo reads, and asks the hazard unit to stall while a result is pending.
//  Replaces the single-cycle multiply path with signed/unsigned multiply and divide support.
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are each WIDTH bits; must be >= 4.
// PORTS
//  clk       in   1      clock, rising edge
//  rst_n     in   1      asynchronous active-low reset
//  start     in   1      issue strobe from EX; accepted only when busy=0 and flush=0
//  op        in   3      operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO (codes in muldiv_pkg)
//  src_a     in   WIDTH  rs value: multiplicand / dividend / MTHI-MTLO data
//  src_b     in   WIDTH  rt value: multiplier / divisor
//  flush     in   1      kill the in-flight operation (branch/exception squash)
//  rd_sel    in   2      01 = read HI, 10 = read LO, 00/11 = no read
//  rd_data   out  WIDTH  combinational: HI for 01, LO for 10, otherwise 0
//  busy      out  1      multi-cycle operation in progress
//  stall     out  1      combinational: busy & (start | rd_sel==01 | rd_sel==10)
//  done      out  1      registered one-cycle pulse: HI/LO just updated by MULT/DIV
//  div_zero  out  1      registered pulse coincident with done: divisor was 0
// BEHAVIOUR
//  Reset (async, rst_n=0): HI=LO=0, state=IDLE, cnt=0, busy=done=div_zero=0.
//  FSM states: IDLE -> RUN -> FIX -> IDLE.
//   IDLE, accepted MUL/DIV op: latch |a| and |b|; signed ops take the absolute value, unsigned pass through.
//     Latch the result-sign flags. cnt=WIDTH-1. Go to RUN.
//   IDLE, accepted MTHI/MTLO: write HI or LO at that edge. Stay in IDLE. No busy, no done.
//   RUN: one shift-add (mul) or restoring-subtract (div) step per cycle.
//     At the edge where cnt==0, go to FIX; otherwise cnt--.
//   FIX: apply sign correction and write HI/LO. Assert done (and div_zero if applicable) for the next cycle.
//     Go to IDLE.
//  Latency: busy is high for exactly WIDTH+1 cycles after the accept edge.
//    New HI/LO and done are visible in the following cycle (WIDTH=32: accept at edge 0, HI/LO/done at edge 33).
//  Multiply: {HI,LO} = 2*WIDTH-bit product. Signed product is negated when sign(a)^sign(b).
//  Divide: LO = quotient, HI = remainder.
//    Quotient is negated when sign(a)^sign(b); remainder takes the sign of the dividend.
//  Divisor 0 (DIV or DIVU): HI=src_a as issued, LO=all ones, div_zero=1 with done.
//  Signed MIN / -1: LO=MIN, HI=0 (two's-complement wrap, no trap).
//  start while busy: ignored. The hazard unit holds the instruction via stall; no queueing.
//  flush: at any edge with flush=1, state->IDLE, busy drops next cycle.
//    HI/LO are unchanged and no done pulse occurs.
//    flush in FIX suppresses the HI/LO write.
//    flush and start in the same cycle: flush wins and start is dropped (MTHI/MTLO included).
//  rd_data always reflects the committed HI/LO. During busy it returns the stale values, but stall is high.
//  Reset mid-operation: abandons the operation and clears HI/LO.
// STRUCTURE
//  muldiv_pkg holds:
//    op codes: MULT=3'd0, MULTU=3'd1, DIV=3'd2, DIVU=3'd3, MTHI=3'd4, MTLO=3'd5; 6/7 are no-ops.
//    rd_sel codes RD_NONE/RD_HI/RD_LO.
//    FSM state constants.
//  One sub-module: muldiv_signfix, a combinational conditional two's-complement negate, parameterised by width.
//    Used for operand abs at issue and for result correction in FIX.
//  The datapath is one shared 2*WIDTH shift register {rem_hi, acc_lo} plus a WIDTH-bit operand register.
// TESTING
//  MULTU a=0xFFFFFFFF b=2.
//    -> busy high for 33 cycles, done pulse once, HI=0x00000001, LO=0xFFFFFFFE.
//  MULT a=-3 b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
//    Back-to-back MULTU 7*6 issued the cycle after done -> HI=0, LO=42.
//  DIV a=-7 b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//    DIVU a=7 b=0 -> HI=7, LO=0xFFFFFFFF, div_zero=1 coincident with done.
//  DIV a=0x80000000 b=0xFFFFFFFF -> LO=0x80000000, HI=0, div_zero=0.
//  MTHI 0x1234 then rd_sel=01 -> rd_data=0x1234 next cycle, stall=0.
//    During MULT, rd_sel=10 -> stall=1 every busy cycle; second start ignored; LO reflects the first op only.
//  MULT 5*5 with flush at cycle 10 -> busy=0 next cycle, no done, HI/LO keep prior values.
//    rst_n=0 at cycle 20 of DIV -> HI=LO=0, busy=0 immediately.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants for the EX-stage multiply/divide unit:
// operation codes, HI/LO read selects and FSM states.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [1:0] RD_NONE = 2'b00;
    localparam logic [1:0] RD_HI   = 2'b01;
    localparam logic [1:0] RD_LO   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate, used for operand
// magnitudes at issue and for result sign correction.
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    // Negate when requested, otherwise pass through.
    always_comb begin
        y = a;
        if (neg) y = ~a + WIDTH'(1);
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers,
// single-cycle MTHI/MTLO, and a stall request while busy.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic [1:0]       rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    state_e           state;
    state_e           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] rem_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             div0;

    logic             accept;
    logic             go_md;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rmd;

    assign accept = start & ~flush & (state == S_IDLE);
    assign go_md  = accept & is_muldiv(op);
    assign sign_a = is_signed_op(op) & src_a[WIDTH-1];
    assign sign_b = is_signed_op(op) & src_b[WIDTH-1];
    assign busy   = (state != S_IDLE);
    assign stall  = busy & (start | (rd_sel == RD_HI) |
                            (rd_sel == RD_LO));

    muldiv_signfix #(.WIDTH(WIDTH)) u_abs_a (
        .neg (sign_a),
        .a   (src_a),
        .y   (abs_a)
    );

    muldiv_signfix #(.WIDTH(WIDTH)) u_abs_b (
        .neg (sign_b),
        .a   (src_b),
        .y   (abs_b)
    );

    muldiv_signfix #(.WIDTH(2*WIDTH)) u_fix_p (
        .neg (neg_q),
        .a   ({rem_hi, acc_lo}),
        .y   (prod)
    );

    muldiv_signfix #(.WIDTH(WIDTH)) u_fix_q (
        .neg (neg_q),
        .a   (acc_lo),
        .y   (quo)
    );

    muldiv_signfix #(.WIDTH(WIDTH)) u_fix_r (
        .neg (neg_r),
        .a   (rem_hi),
        .y   (rmd)
    );

    // Architectural register read, stale while busy.
    always_comb begin
        rd_data = '0;
        case (rd_sel)
            RD_HI:   rd_data = hi;
            RD_LO:   rd_data = lo;
            default: rd_data = '0;
        endcase
    end

    // One iteration: shift-add for multiply,
    // restoring subtract for divide.
    always_comb begin
        mul_sum  = {1'b0, rem_hi} +
                   (acc_lo[0] ? {1'b0, opnd} : '0);
        div_sh   = {rem_hi, acc_lo[WIDTH-1]};
        div_diff = div_sh - {1'b0, opnd};
        step_hi  = mul_sum[WIDTH:1];
        step_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};
        if (is_div) begin
            if (div_diff[WIDTH]) begin
                step_hi = div_sh[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end else begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state: flush always returns to idle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (go_md) state_nxt = S_RUN;
            S_RUN:   if (cnt == '0) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    // Datapath, HI/LO commit and completion pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            rem_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div0     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go_md) begin
                        rem_hi <= '0;
                        acc_lo <= abs_a;
                        opnd   <= abs_b;
                        is_div <= (op == OP_DIV) |
                                  (op == OP_DIVU);
                        neg_q  <= sign_a ^ sign_b;
                        neg_r  <= sign_a;
                        div0   <= ((op == OP_DIV) |
                                   (op == OP_DIVU)) &
                                  (src_b == '0);
                        cnt    <= CW'(WIDTH - 1);
                    end else if (accept && op == OP_MTHI) begin
                        hi <= src_a;
                    end else if (accept && op == OP_MTLO) begin
                        lo <= src_a;
                    end
                end
                S_RUN: begin
                    rem_hi <= step_hi;
                    acc_lo <= step_lo;
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                S_FIX: begin
                    if (!flush) begin
                        if (is_div) begin
                            hi <= rmd;
                            lo <= div0 ? '1 : quo;
                        end else begin
                            hi <= prod[2*WIDTH-1:WIDTH];
                            lo <= prod[WIDTH-1:0];
                        end
                        done     <= 1'b1;
                        div_zero <= div0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit against an
// arithmetic reference model of HI/LO.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         flush = 1'b0;
    logic [1:0]   rd_sel = RD_NONE;
    logic [W-1:0] rd_data;
    logic         busy;
    logic         stall;
    logic         done;
    logic         div_zero;

    int total = 0;
    int bad = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_dz = 1'b0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .flush    (flush),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp_v);
        end
    endtask

    function automatic void model(input logic [2:0] o,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
        int          sa;
        int          sb;
        longint      ps;
        longint unsigned pu;
        sa = int'(a);
        sb = int'(b);
        m_dz = 1'b0;
        case (o)
            OP_MULT: begin
                ps = longint'(sa) * longint'(sb);
                m_hi = ps[63:32];
                m_lo = ps[31:0];
            end
            OP_MULTU: begin
                pu = {32'd0, a} * {32'd0, b};
                m_hi = pu[63:32];
                m_lo = pu[31:0];
            end
            OP_DIV, OP_DIVU: begin
                if (b == 32'd0) begin
                    m_hi = a;
                    m_lo = 32'hFFFF_FFFF;
                    m_dz = 1'b1;
                end else if (o == OP_DIVU) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end else if (a == 32'h8000_0000 &&
                             b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000;
                    m_hi = 32'd0;
                end else begin
                    m_lo = sa / sb;
                    m_hi = sa % sb;
                end
            end
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            default: ;
        endcase
    endfunction

    task automatic check_hilo(input string tag);
        rd_sel = RD_HI;
        #1;
        chk({tag, "_hi"}, rd_data, m_hi);
        rd_sel = RD_LO;
        #1;
        chk({tag, "_lo"}, rd_data, m_lo);
        rd_sel = RD_NONE;
        #1;
    endtask

    task automatic run_md(input string tag, input logic [2:0] o,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input bit contend);
        int n;
        op = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        #1;
        chk({tag, "_issue_stall"}, 32'(stall), 32'd0);
        tick;
        chk({tag, "_first_done"}, 32'(done), 32'd0);
        if (contend) begin
            op = OP_MULTU;
            src_a = $urandom;
            src_b = $urandom;
            rd_sel = RD_LO;
        end else begin
            start = 1'b0;
        end
        n = 0;
        while (busy && n < 100) begin
            if (contend) chk({tag, "_stall"}, 32'(stall), 32'd1);
            n++;
            tick;
        end
        start = 1'b0;
        rd_sel = RD_NONE;
        model(o, a, b);
        chk({tag, "_busy_len"}, n, W + 1);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_dz"}, 32'(div_zero), 32'(m_dz));
        check_hilo(tag);
    endtask

    task automatic run_single(input string tag, input logic [2:0] o,
                              input logic [31:0] a);
        op = o;
        src_a = a;
        start = 1'b1;
        tick;
        start = 1'b0;
        model(o, a, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        check_hilo(tag);
    endtask

    initial begin
        bit          seen;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dz", 32'(div_zero), 32'd0);
        check_hilo("rst");
        rd_sel = 2'b11;
        #1;
        chk("rd_sel11", rd_data, 32'd0);
        rd_sel = RD_NONE;
        rst_n = 1'b1;
        tick;

        run_md("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        tick;
        chk("done_once", 32'(done), 32'd0);
        run_md("mult_neg", OP_MULT, -32'sd3, 32'd5, 1'b0);
        run_md("b2b_multu", OP_MULTU, 32'd7, 32'd6, 1'b0);
        run_md("div_neg", OP_DIV, -32'sd7, 32'd2, 1'b0);
        run_md("divu_zero", OP_DIVU, 32'd7, 32'd0, 1'b0);
        run_md("div_min", OP_DIV, 32'h8000_0000,
               32'hFFFF_FFFF, 1'b0);
        run_md("div_zero_s", OP_DIV, -32'sd9, 32'd0, 1'b0);

        run_single("mthi", OP_MTHI, 32'h1234);
        rd_sel = RD_HI;
        #1;
        chk("mthi_rd", rd_data, 32'h1234);
        chk("mthi_stall", 32'(stall), 32'd0);
        rd_sel = RD_NONE;
        run_single("mtlo", OP_MTLO, 32'h5678_9ABC);

        run_md("contend", OP_MULT, 32'd1000, -32'sd77, 1'b1);

        op = OP_MULT;
        src_a = 32'd5;
        src_b = 32'd5;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (9) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen |= done;
            tick;
        end
        chk("flush_nodone", 32'(seen), 32'd0);
        check_hilo("flush");

        op = OP_MTHI;
        src_a = 32'hDEAD_BEEF;
        start = 1'b1;
        flush = 1'b1;
        tick;
        start = 1'b0;
        flush = 1'b0;
        check_hilo("flush_mthi");

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if (is_muldiv(ro))
                run_md("rand", ro, ra, rb, 1'b0);
            else
                run_single("rand_1c", ro, ra);
        end

        op = OP_DIV;
        src_a = 32'h7654_3210;
        src_b = 32'd3;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (19) tick;
        rst_n = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        chk("midrst_busy", 32'(busy), 32'd0);
        check_hilo("midrst");
        rst_n = 1'b1;
        tick;
        run_md("post_rst", OP_MULTU, 32'd9, 32'd11, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
